// File: rtl/dmem_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : dmem_arbiter_if
// Description : Bundles the two request ports, the shared response bus and
//               the data-memory access port of the data-memory arbiter.
//               The slave modport is the arbiter's view. The master modport
//               is the view of the requesters and memory around it.
// Revision    : 1.0 - initial release
// ============================================================================
interface dmem_arbiter_if;

  // Port 0 (load/store unit) request
  logic        p0_req_valid;
  logic        p0_req_ready;
  logic        p0_req_we;
  logic [31:0] p0_req_addr;
  logic [31:0] p0_req_wdata;
  logic [3:0]  p0_req_be;

  // Port 1 (debug/loader) request
  logic        p1_req_valid;
  logic        p1_req_ready;
  logic        p1_req_we;
  logic [31:0] p1_req_addr;
  logic [31:0] p1_req_wdata;
  logic [3:0]  p1_req_be;

  // Shared response bus, qualified per port by rsp_valid
  logic        p0_rsp_valid;
  logic        p1_rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  // Single-port data memory
  logic        mem_wen;
  logic [31:0] mem_address;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_byte_mask;
  logic [31:0] mem_rdata;

  modport slave (
    input  p0_req_valid, p0_req_we, p0_req_addr, p0_req_wdata, p0_req_be,
    input  p1_req_valid, p1_req_we, p1_req_addr, p1_req_wdata, p1_req_be,
    input  mem_rdata,
    output p0_req_ready, p1_req_ready,
    output p0_rsp_valid, p1_rsp_valid, rsp_rdata, rsp_err,
    output mem_wen, mem_address, mem_wdata, mem_byte_mask
  );

  modport master (
    output p0_req_valid, p0_req_we, p0_req_addr, p0_req_wdata, p0_req_be,
    output p1_req_valid, p1_req_we, p1_req_addr, p1_req_wdata, p1_req_be,
    output mem_rdata,
    input  p0_req_ready, p1_req_ready,
    input  p0_rsp_valid, p1_rsp_valid, rsp_rdata, rsp_err,
    input  mem_wen, mem_address, mem_wdata, mem_byte_mask
  );

endinterface
`default_nettype wire

// File: rtl/dmem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : dmem_arbiter
// Description : Two-requester arbiter and access sequencer for the single-port
//               data memory. It accepts one request per IDLE cycle and drives
//               the memory for one ACCESS cycle. It then returns a registered
//               response to the port that won.
// Revision    : 1.0 - initial release
// ============================================================================
module dmem_arbiter #(
  parameter int WORDS      = 128,
  parameter int FIXED_PRIO = 0
) (
  input  logic          clk,
  input  logic          rst_n,
  dmem_arbiter_if.slave bus
);

  // Highest byte address at which a full word still fits inside the memory
  localparam logic [31:0] c_MAX_ADDR = 32'(WORDS * 4 - 4);

  typedef enum logic [0:0] {
    S_IDLE   = 1'b0,
    S_ACCESS = 1'b1
  } state_t;

  state_t      r_state;
  logic        r_last_grant;   // 0 = port 0 won last, 1 = port 1 won last

  // Latched request
  logic        r_we;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic [3:0]  r_be;
  logic        r_port;
  logic        r_err;

  // Registered response
  logic        r_rsp_valid0;
  logic        r_rsp_valid1;
  logic [31:0] r_rsp_rdata;
  logic        r_rsp_err;

  // Arbitration and request selection
  logic        w_idle;
  logic        w_tie_to_p0;
  logic        w_grant0;
  logic        w_grant1;
  logic        w_hs;
  logic        w_sel_we;
  logic [31:0] w_sel_addr;
  logic [31:0] w_sel_wdata;
  logic [3:0]  w_sel_be;
  logic        w_sel_err;

  // Pick the winner: a lone valid wins, ties go by priority or round-robin
  always_comb begin
    w_idle      = (r_state == S_IDLE) && rst_n;
    w_tie_to_p0 = (FIXED_PRIO != 0) || r_last_grant;
    w_grant0    = w_idle && bus.p0_req_valid && (!bus.p1_req_valid || w_tie_to_p0);
    w_grant1    = w_idle && bus.p1_req_valid && (!bus.p0_req_valid || !w_tie_to_p0);
    w_hs        = w_grant0 || w_grant1;
    w_sel_we    = w_grant1 ? bus.p1_req_we    : bus.p0_req_we;
    w_sel_addr  = w_grant1 ? bus.p1_req_addr  : bus.p0_req_addr;
    w_sel_wdata = w_grant1 ? bus.p1_req_wdata : bus.p0_req_wdata;
    w_sel_be    = w_grant1 ? bus.p1_req_be    : bus.p0_req_be;
    // Plain unsigned compare: addresses near 2^32 cannot wrap back into range
    w_sel_err   = (w_sel_addr > c_MAX_ADDR);
  end

  // Sequencer: latch on handshake, then capture the memory read at the end of ACCESS
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_last_grant <= 1'b1;
      r_we         <= 1'b0;
      r_addr       <= 32'd0;
      r_wdata      <= 32'd0;
      r_be         <= 4'd0;
      r_port       <= 1'b0;
      r_err        <= 1'b0;
      r_rsp_valid0 <= 1'b0;
      r_rsp_valid1 <= 1'b0;
      r_rsp_rdata  <= 32'd0;
      r_rsp_err    <= 1'b0;
    end else begin
      r_rsp_valid0 <= 1'b0;
      r_rsp_valid1 <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_hs) begin
            r_state      <= S_ACCESS;
            r_last_grant <= w_grant1;
            r_port       <= w_grant1;
            r_we         <= w_sel_we;
            r_addr       <= w_sel_addr;
            r_wdata      <= w_sel_wdata;
            r_be         <= w_sel_be;
            r_err        <= w_sel_err;
          end
        end
        S_ACCESS: begin
          r_state     <= S_IDLE;
          // For stores the memory forwards the merged word, so it is returned too
          r_rsp_rdata <= r_err ? 32'd0 : bus.mem_rdata;
          r_rsp_err   <= r_err;
          if (r_port) begin
            r_rsp_valid1 <= 1'b1;
          end else begin
            r_rsp_valid0 <= 1'b1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.p0_req_ready  = w_grant0;
  assign bus.p1_req_ready  = w_grant1;

  assign bus.p0_rsp_valid  = r_rsp_valid0;
  assign bus.p1_rsp_valid  = r_rsp_valid1;
  assign bus.rsp_rdata     = r_rsp_rdata;
  assign bus.rsp_err       = r_rsp_err;

  // rst_n gates the write directly so a reset in ACCESS suppresses the store
  assign bus.mem_wen       = (r_state == S_ACCESS) && r_we && !r_err && rst_n;
  assign bus.mem_address   = r_addr;
  assign bus.mem_wdata     = r_wdata;
  assign bus.mem_byte_mask = r_be;

endmodule
`default_nettype wire

// File: tb/tb_dmem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_dmem_arbiter
// Description : Self-checking bench for dmem_arbiter. It runs a round-robin
//               instance with a behavioural memory, and a fixed-priority
//               instance whose memory returns the inverted address.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_dmem_arbiter;

  localparam int WORDS = 128;
  localparam int AW    = $clog2(WORDS);

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   n_cmp  = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  dmem_arbiter_if bus0 ();
  dmem_arbiter_if bus1 ();

  dmem_arbiter #(.WORDS(WORDS), .FIXED_PRIO(0)) u_rr (.clk(clk), .rst_n(rst_n), .bus(bus0));
  dmem_arbiter #(.WORDS(WORDS), .FIXED_PRIO(1)) u_fp (.clk(clk), .rst_n(rst_n), .bus(bus1));

  // Byte-lane merge: bit i of be replaces byte i
  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw,
                                        input logic [3:0] be);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (be[b]) r[8*b +: 8] = nw[8*b +: 8];
    return r;
  endfunction

  // Environment memory: asynchronous, write-forwarding read, commit on the edge
  logic [31:0]   sram [WORDS];
  logic [AW-1:0] sidx;
  assign sidx = bus0.mem_address[AW+1:2];
  assign bus0.mem_rdata = bus0.mem_wen ? merge(sram[sidx], bus0.mem_wdata, bus0.mem_byte_mask)
                                       : sram[sidx];
  always @(posedge clk) if (bus0.mem_wen) sram[sidx] <= merge(sram[sidx], bus0.mem_wdata, bus0.mem_byte_mask);

  assign bus1.mem_rdata = ~bus1.mem_address;

  // Transaction-level reference: memory contents and the last winner
  logic [31:0] model_mem [WORDS];
  int          model_last = 1;

  function automatic logic is_err(input logic [31:0] a);
    return a > 32'(WORDS * 4 - 4);
  endfunction

  task automatic drive(input int port, input logic v, input logic we, input logic [31:0] a,
                       input logic [31:0] d, input logic [3:0] be);
    if (port == 0) begin
      bus0.p0_req_valid = v; bus0.p0_req_we = we; bus0.p0_req_addr = a;
      bus0.p0_req_wdata = d; bus0.p0_req_be = be;
    end else begin
      bus0.p1_req_valid = v; bus0.p1_req_we = we; bus0.p1_req_addr = a;
      bus0.p1_req_wdata = d; bus0.p1_req_be = be;
    end
  endtask

  // One isolated request on the round-robin instance, checked cycle by cycle
  task automatic single_txn(input int port, input logic we, input logic [31:0] a,
                            input logic [31:0] d, input logic [3:0] be, input string tag);
    logic        err;
    logic [31:0] exp_rd;
    logic [AW-1:0] idx;
    logic        rdy_w, rdy_l, rv_w, rv_l;
    err = is_err(a);
    idx = a[AW+1:2];
    @(negedge clk);
    drive(port, 1'b1, we, a, d, be);
    drive(1 - port, 1'b0, 1'b0, 32'd0, 32'd0, 4'd0);
    #1;
    rdy_w = (port == 0) ? bus0.p0_req_ready : bus0.p1_req_ready;
    rdy_l = (port == 0) ? bus0.p1_req_ready : bus0.p0_req_ready;
    n_cmp++; if (rdy_w !== 1'b1) begin n_fail++; $display("FAIL %s winner_ready got=%b want=1", tag, rdy_w); end
    n_cmp++; if (rdy_l !== 1'b0) begin n_fail++; $display("FAIL %s loser_ready got=%b want=0", tag, rdy_l); end
    n_cmp++; if ({bus0.p0_rsp_valid, bus0.p1_rsp_valid, bus0.mem_wen} !== 3'b000) begin
      n_fail++; $display("FAIL %s idle_rsp_wen got=%b want=000", tag, {bus0.p0_rsp_valid, bus0.p1_rsp_valid, bus0.mem_wen}); end
    model_last = port;
    @(negedge clk);
    drive(port, 1'b0, 1'b0, 32'd0, 32'd0, 4'd0);
    n_cmp++; if (bus0.mem_wen !== (we && !err)) begin n_fail++; $display("FAIL %s mem_wen got=%b want=%b", tag, bus0.mem_wen, we && !err); end
    n_cmp++; if (bus0.mem_address !== a) begin n_fail++; $display("FAIL %s mem_address got=%h want=%h", tag, bus0.mem_address, a); end
    n_cmp++; if (bus0.mem_wdata !== d) begin n_fail++; $display("FAIL %s mem_wdata got=%h want=%h", tag, bus0.mem_wdata, d); end
    n_cmp++; if (bus0.mem_byte_mask !== be) begin n_fail++; $display("FAIL %s mem_byte_mask got=%h want=%h", tag, bus0.mem_byte_mask, be); end
    n_cmp++; if ({bus0.p0_req_ready, bus0.p1_req_ready} !== 2'b00) begin n_fail++; $display("FAIL %s access_ready got=%b want=00", tag, {bus0.p0_req_ready, bus0.p1_req_ready}); end
    if (err) exp_rd = 32'd0;
    else begin
      exp_rd = we ? merge(model_mem[idx], d, be) : model_mem[idx];
      if (we) model_mem[idx] = exp_rd;
    end
    @(negedge clk);
    rv_w = (port == 0) ? bus0.p0_rsp_valid : bus0.p1_rsp_valid;
    rv_l = (port == 0) ? bus0.p1_rsp_valid : bus0.p0_rsp_valid;
    n_cmp++; if ({rv_w, rv_l} !== 2'b10) begin n_fail++; $display("FAIL %s rsp_valid got=%b want=10", tag, {rv_w, rv_l}); end
    n_cmp++; if (bus0.rsp_rdata !== exp_rd) begin n_fail++; $display("FAIL %s rsp_rdata got=%h want=%h", tag, bus0.rsp_rdata, exp_rd); end
    n_cmp++; if (bus0.rsp_err !== err) begin n_fail++; $display("FAIL %s rsp_err got=%b want=%b", tag, bus0.rsp_err, err); end
    n_cmp++; if (bus0.mem_wen !== 1'b0) begin n_fail++; $display("FAIL %s wen_after got=%b want=0", tag, bus0.mem_wen); end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    drive(0, 1'b1, 1'b1, 32'h10, 32'hFFFF_FFFF, 4'hF);
    drive(1, 1'b1, 1'b1, 32'h20, 32'hFFFF_FFFF, 4'hF);
    bus1.p0_req_valid = 1'b1; bus1.p1_req_valid = 1'b1;
    repeat (3) @(negedge clk);
    n_cmp++; if ({bus0.p0_req_ready, bus0.p1_req_ready, bus1.p0_req_ready, bus1.p1_req_ready} !== 4'b0) begin
      n_fail++; $display("FAIL reset_ready got=%b want=0000", {bus0.p0_req_ready, bus0.p1_req_ready, bus1.p0_req_ready, bus1.p1_req_ready}); end
    n_cmp++; if ({bus0.p0_rsp_valid, bus0.p1_rsp_valid, bus0.rsp_err, bus0.mem_wen} !== 4'b0) begin
      n_fail++; $display("FAIL reset_flags got=%b want=0000", {bus0.p0_rsp_valid, bus0.p1_rsp_valid, bus0.rsp_err, bus0.mem_wen}); end
    n_cmp++; if (bus0.rsp_rdata !== 32'd0) begin n_fail++; $display("FAIL reset_rdata got=%h want=0", bus0.rsp_rdata); end
    n_cmp++; if ({bus0.mem_address, bus0.mem_wdata, bus0.mem_byte_mask} !== 68'd0) begin
      n_fail++; $display("FAIL reset_membus got=%h/%h/%h want=0", bus0.mem_address, bus0.mem_wdata, bus0.mem_byte_mask); end
    drive(0, 1'b0, 1'b0, 32'd0, 32'd0, 4'd0);
    drive(1, 1'b0, 1'b0, 32'd0, 32'd0, 4'd0);
    bus1.p0_req_valid = 1'b0; bus1.p1_req_valid = 1'b0;
    rst_n = 1'b1;
    model_last = 1;
  endtask

  task automatic test_store_load();
    single_txn(0, 1'b1, 32'h10, 32'hAABB_CCDD, 4'hF, "p0_store");
    single_txn(0, 1'b0, 32'h10, 32'h0, 4'h0, "p0_load");
  endtask

  task automatic test_byte_mask();
    single_txn(0, 1'b1, 32'h10, 32'h0000_EE00, 4'h2, "be_store");
    single_txn(1, 1'b0, 32'h10, 32'h0, 4'h0, "be_load");
    single_txn(1, 1'b1, 32'h24, $urandom, 4'h0, "be_zero_store");
    single_txn(0, 1'b0, 32'h24, 32'h0, 4'h0, "be_zero_load");
  endtask

  task automatic test_addr_err();
    single_txn(1, 1'b1, 32'h1FD, $urandom, 4'hF, "err_store_1fd");
    single_txn(0, 1'b0, 32'hFFFF_FFFF, 32'h0, 4'h0, "err_load_ffffffff");
    single_txn(1, 1'b0, 32'h1FC, 32'h0, 4'h0, "ok_load_1fc");
  endtask

  // Both ports held valid: grants follow round-robin, one handshake every 2 cycles
  task automatic test_back_to_back();
    logic [31:0] a [2];
    logic [31:0] exp_rd;
    int          w;
    a[0] = {23'd0, 7'($urandom_range(0, WORDS - 1)), 2'b00};
    a[1] = {23'd0, 7'($urandom_range(0, WORDS - 1)), 2'b00};
    @(negedge clk);
    drive(0, 1'b1, 1'b0, a[0], 32'd0, 4'd0);
    drive(1, 1'b1, 1'b0, a[1], 32'd0, 4'd0);
    for (int k = 0; k < 4; k++) begin
      #1;
      w = (model_last == 1) ? 0 : 1;
      n_cmp++; if ({bus0.p0_req_ready, bus0.p1_req_ready} !== ((w == 0) ? 2'b10 : 2'b01)) begin
        n_fail++; $display("FAIL b2b_grant%0d got=%b want_port=%0d", k, {bus0.p0_req_ready, bus0.p1_req_ready}, w); end
      model_last = w;
      exp_rd = model_mem[a[w][AW+1:2]];
      @(negedge clk);
      n_cmp++; if ({bus0.p0_req_ready, bus0.p1_req_ready} !== 2'b00) begin
        n_fail++; $display("FAIL b2b_access_ready%0d got=%b want=00", k, {bus0.p0_req_ready, bus0.p1_req_ready}); end
      @(negedge clk);
      if (k == 3) begin
        drive(0, 1'b0, 1'b0, 32'd0, 32'd0, 4'd0);
        drive(1, 1'b0, 1'b0, 32'd0, 32'd0, 4'd0);
      end
      n_cmp++; if ({bus0.p0_rsp_valid, bus0.p1_rsp_valid} !== ((w == 0) ? 2'b10 : 2'b01)) begin
        n_fail++; $display("FAIL b2b_rsp_port%0d got=%b want_port=%0d", k, {bus0.p0_rsp_valid, bus0.p1_rsp_valid}, w); end
      n_cmp++; if (bus0.rsp_rdata !== exp_rd) begin
        n_fail++; $display("FAIL b2b_rdata%0d got=%h want=%h", k, bus0.rsp_rdata, exp_rd); end
    end
  endtask

  // Fixed priority instance: port 1 starves until port 0 drops valid
  task automatic test_fixed_prio();
    logic [31:0] a0, a1;
    a0 = {$urandom_range(0, 127), 2'b00};
    a1 = {$urandom_range(0, 127), 2'b00};
    @(negedge clk);
    bus1.p0_req_valid = 1'b1; bus1.p0_req_we = 1'b0; bus1.p0_req_addr = a0;
    bus1.p1_req_valid = 1'b1; bus1.p1_req_we = 1'b0; bus1.p1_req_addr = a1;
    for (int k = 0; k < 3; k++) begin
      #1;
      n_cmp++; if ({bus1.p0_req_ready, bus1.p1_req_ready} !== 2'b10) begin
        n_fail++; $display("FAIL fp_grant%0d got=%b want=10", k, {bus1.p0_req_ready, bus1.p1_req_ready}); end
      @(negedge clk);
      @(negedge clk);
      if (k == 2) bus1.p0_req_valid = 1'b0;
      n_cmp++; if ({bus1.p0_rsp_valid, bus1.p1_rsp_valid, bus1.rsp_rdata} !== {2'b10, ~a0}) begin
        n_fail++; $display("FAIL fp_rsp%0d got=%b/%h want=10/%h", k, {bus1.p0_rsp_valid, bus1.p1_rsp_valid}, bus1.rsp_rdata, ~a0); end
    end
    #1;
    n_cmp++; if ({bus1.p0_req_ready, bus1.p1_req_ready} !== 2'b01) begin
      n_fail++; $display("FAIL fp_p1_grant got=%b want=01", {bus1.p0_req_ready, bus1.p1_req_ready}); end
    @(negedge clk);
    bus1.p1_req_valid = 1'b0;
    @(negedge clk);
    n_cmp++; if ({bus1.p0_rsp_valid, bus1.p1_rsp_valid, bus1.rsp_rdata} !== {2'b01, ~a1}) begin
      n_fail++; $display("FAIL fp_p1_rsp got=%b/%h want=01/%h", {bus1.p0_rsp_valid, bus1.p1_rsp_valid}, bus1.rsp_rdata, ~a1); end
  endtask

  task automatic test_reset_access();
    @(negedge clk);
    drive(0, 1'b1, 1'b1, 32'h10, 32'h1234_5678, 4'hF);
    #1;
    n_cmp++; if (bus0.p0_req_ready !== 1'b1) begin n_fail++; $display("FAIL rst_acc_ready got=%b want=1", bus0.p0_req_ready); end
    @(negedge clk);
    drive(0, 1'b0, 1'b0, 32'd0, 32'd0, 4'd0);
    rst_n = 1'b0;
    #1;
    n_cmp++; if (bus0.mem_wen !== 1'b0) begin n_fail++; $display("FAIL rst_acc_wen got=%b want=0", bus0.mem_wen); end
    @(negedge clk);
    n_cmp++; if ({bus0.p0_rsp_valid, bus0.p1_rsp_valid, bus0.rsp_err} !== 3'b000) begin
      n_fail++; $display("FAIL rst_acc_rsp got=%b want=000", {bus0.p0_rsp_valid, bus0.p1_rsp_valid, bus0.rsp_err}); end
    n_cmp++; if ({bus0.rsp_rdata, bus0.mem_address, bus0.mem_wdata, bus0.mem_byte_mask} !== 100'd0) begin
      n_fail++; $display("FAIL rst_acc_regs got=%h/%h/%h/%h want=0", bus0.rsp_rdata, bus0.mem_address, bus0.mem_wdata, bus0.mem_byte_mask); end
    rst_n = 1'b1;
    model_last = 1;
    single_txn(1, 1'b0, 32'h10, 32'h0, 4'h0, "rst_acc_reload");
  endtask

  task automatic test_random();
    logic [31:0] a;
    for (int i = 0; i < 40; i++) begin
      a = ($urandom_range(0, 9) == 0) ? $urandom : 32'($urandom_range(0, WORDS * 4 - 1));
      single_txn(int'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), a, $urandom,
                 4'($urandom_range(0, 15)), $sformatf("rand%0d", i));
    end
  endtask

  initial begin
    for (int i = 0; i < WORDS; i++) begin
      sram[i]      = $urandom;
      model_mem[i] = sram[i];
    end
    bus1.p0_req_valid = 1'b0; bus1.p0_req_we = 1'b0; bus1.p0_req_addr = 32'd0;
    bus1.p0_req_wdata = 32'd0; bus1.p0_req_be = 4'd0;
    bus1.p1_req_valid = 1'b0; bus1.p1_req_we = 1'b0; bus1.p1_req_addr = 32'd0;
    bus1.p1_req_wdata = 32'd0; bus1.p1_req_be = 4'd0;
    test_reset();
    test_store_load();
    test_byte_mask();
    test_back_to_back();
    test_fixed_prio();
    test_addr_err();
    test_reset_access();
    test_random();
    @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog timeout compared=%0d", n_cmp);
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire

// File: doc/dmem_arbiter.md
# dmem_arbiter

Two-requester arbiter and access sequencer for the single-port data memory. The core load/store unit (port 0) and the debug/loader port (port 1) share the memory through it. It accepts one request at a time over a valid/ready handshake, drives the memory's write-enable, address, write-data and byte-mask for exactly one access cycle, and returns a registered read response to the winning requester. It sits between the LSU/debug master and the data memory; the memory's asynchronous, write-forwarding read is captured here.

## Interface
- `WORDS`, 128: memory depth in 32-bit words; legal byte addresses are 0..WORDS*4-4.
- `FIXED_PRIO`, 0: 0 = round-robin between ports; 1 = port 0 always wins ties.
- `clk` in 1: single clock; all state updates on rising edge.
- `rst_n` in 1: reset, synchronous, active-low.
- `p0_req_valid`, `p1_req_valid` in 1: request pending.
- `p0_req_ready`, `p1_req_ready` out 1: request accepted this cycle when valid is also high.
- `p0_req_we`, `p1_req_we` in 1: 1 = store, 0 = load.
- `p0_req_addr`, `p1_req_addr` in 32: byte address.
- `p0_req_wdata`, `p1_req_wdata` in 32: store data.
- `p0_req_be`, `p1_req_be` in 4: byte mask, bit i selects byte address+i.
- `p0_rsp_valid`, `p1_rsp_valid` out 1: one-cycle response pulse.
- `rsp_rdata` out 32: response data, shared by both ports; qualified by the rsp_valid signals.
- `rsp_err` out 1: response is an address error; qualified by the rsp_valid signals.
- `mem_wen` out 1: memory write enable.
- `mem_address` out 32: memory byte address.
- `mem_wdata` out 32: memory write data.
- `mem_byte_mask` out 4: memory byte mask.
- `mem_rdata` in 32: memory asynchronous read data.

## Operation
- **FSM states:**
  - IDLE → ACCESS on any handshake.
  - ACCESS → IDLE unconditionally.
- **Arbitration (IDLE only):**
  - Only one ready is ever high at a time, and only for the winner.
  - ready is high only when the state is IDLE and rst_n = 1.
  - If exactly one valid is high, that port wins.
  - If both are high and FIXED_PRIO = 1, port 0 wins.
  - If both are high and FIXED_PRIO = 0, the port that did not win last wins.
  - `last_grant` updates only on a handshake.
  - `ready` may depend combinationally on `valid`; valid must not depend on ready.
- **Handshake:**
  - The winner's we/addr/wdata/be and port id are latched into the request register.
  - Error flag = addr > WORDS*4-4, i.e. no unsigned wrap and addr+3 must be in range. It is latched at the same time.
- **ACCESS:**
  - `mem_address`, `mem_wdata` and `mem_byte_mask` come from the latched request.
  - `mem_wen` = ACCESS && we && !err && rst_n.
  - At the end of ACCESS, `rsp_rdata` is loaded with err ? 0 : mem_rdata. For stores this is the forwarded, merged word.
  - At the same edge, `rsp_err` is loaded with err and the latched port's rsp_valid is set.
- **Outside ACCESS:**
  - mem_wen = 0.
  - mem_address/wdata/mask hold the last latched values.
  - byte_mask = 0 is legal: no bytes are written, and a response is still issued.
- **Responses:** there is no response backpressure. A requester must accept rsp_valid whenever it has an outstanding request. Each port has at most one request outstanding.

## Timing
- **Reset values (rst_n low at an edge):**
  - State = IDLE; last_grant = port 1 (so port 0 wins the first RR tie).
  - Both rsp_valid = 0; rsp_rdata = 0; rsp_err = 0.
  - Request register = 0, so mem_address = 0, mem_wdata = 0, mem_byte_mask = 0.
  - mem_wen = 0 and both ready = 0 while rst_n is low.
- **Latency:**
  - Handshake in cycle N.
  - Memory driven in cycle N+1; a store commits at the end of N+1.
  - rsp_valid is high during N+2 only.
- **Throughput:** one access per 2 cycles. A new handshake may occur in cycle N+2, concurrently with the response.
- **Read-after-write:** a store accepted at N is visible to a load accepted at N+2 or later.
- **Reset in ACCESS (sync reset asserted during ACCESS):**
  - The write is suppressed.
  - No response is issued.
  - State returns to IDLE next cycle.
- **Simultaneous valids:** exactly one handshake; the loser's valid stays asserted and is served in the next IDLE.

## Test plan
- **Port 0 store:** store addr 0x10, wdata 0xAABBCCDD, be 0xF. Then load 0x10.
  - Store: mem_wen high exactly one cycle (N+1); p0_rsp_valid at N+2 with rdata 0xAABBCCDD.
  - Load: rdata 0xAABBCCDD, err 0.
- **Byte-masked store:** store be 0x2, wdata 0x0000EE00 to the same word. Then load.
  - Store: rsp_rdata 0xAABBEEDD.
  - Load: 0xAABBEEDD.
- **Both ports valid for 4 handshakes, FIXED_PRIO = 0:**
  - Grants alternate p0, p1, p0, p1.
  - Handshakes every 2 cycles; each rsp_valid goes to the correct port.
- **Both ports valid, FIXED_PRIO = 1:** p0 held valid continuously; p1 is never granted until p0 drops valid, then p1 is granted in the next IDLE.
- **Address errors, WORDS = 128:**
  - Store to 0x1FD: mem_wen stays 0; rsp_err = 1, rsp_rdata = 0.
  - Load from 0xFFFFFFFF: rsp_err = 1.
  - Load from 0x1FC: rsp_err = 0.
- **Reset during ACCESS:**
  - rst_n low in the ACCESS cycle of a store: no write, no rsp_valid; outputs return to reset values.
  - A following load returns the old data.
